// File: rtl/bp_be_long_ctl.sv
// Sequencer for the iterative long-latency unit (int div/rem, fp div/sqrt).
// Counts the unit latency, holds the result for writeback and publishes in-flight hazard state.
module bp_be_long_ctl #(
  parameter int lat_int_p = 34,
  parameter int lat_fp_p  = 20
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_v_i,
  output logic       cmd_ready_o,
  input  logic       cmd_fp_i,
  input  logic [4:0] cmd_rd_addr_i,
  input  logic       flush_i,
  output logic       unit_start_o,
  output logic       wb_v_o,
  input  logic       wb_ready_i,
  output logic       wb_fp_o,
  output logic [4:0] wb_rd_addr_o,
  output logic       long_busy_o,
  output logic       busy_iwb_v_o,
  output logic       busy_fwb_v_o,
  output logic [4:0] busy_rd_addr_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_WB = 2'd2
  } state_e;

  // Counter is preloaded with lat-1 so that wb_v_o rises exactly lat cycles after accept.
  localparam logic [7:0] LAT_INT_M1 = 8'(lat_int_p - 1);
  localparam logic [7:0] LAT_FP_M1  = 8'(lat_fp_p - 1);

  state_e     state_q, state_d;
  logic       fp_q, fp_d;
  logic [4:0] rd_q, rd_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d;

  logic accept;
  logic retire;
  logic in_flight;

  assign in_flight = (state_q != IDLE);
  assign accept    = cmd_v_i & cmd_ready_o;
  assign retire    = wb_v_o & wb_ready_i;

  // All outputs are forced low while reset is asserted, even before the state register clears.
  assign cmd_ready_o    = (state_q == IDLE) & ~flush_i & reset_i;
  assign wb_v_o         = (state_q == WAIT_WB) & ~flush_i & reset_i;
  assign wb_fp_o        = fp_q & reset_i;
  assign wb_rd_addr_o   = rd_q & {5{reset_i}};
  assign unit_start_o   = start_q & reset_i;
  assign long_busy_o    = in_flight & reset_i;
  assign busy_iwb_v_o   = in_flight & ~fp_q & reset_i;
  assign busy_fwb_v_o   = in_flight & fp_q & reset_i;
  assign busy_rd_addr_o = rd_q & {5{reset_i}};

  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          fp_d    = cmd_fp_i;
          rd_d    = cmd_rd_addr_i;
          cnt_d   = cmd_fp_i ? LAT_FP_M1 : LAT_INT_M1;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q <= 8'd1) begin
          // Counter parks at 1 rather than wrapping.
          state_d = WAIT_WB;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WAIT_WB: begin
        if (flush_i || retire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      fp_q    <= 1'b0;
      rd_q    <= 5'd0;
      cnt_q   <= 8'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

endmodule

// File: tb/tb_bp_be_long_ctl.sv
// Bench for bp_be_long_ctl: op table with per-cycle expectations and a writeback scoreboard,
// plus hand-written reset and idle-flush sequences.
module tb_bp_be_long_ctl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_v;
  logic       cmd_ready;
  logic       cmd_fp;
  logic [4:0] cmd_rd;
  logic       flush;
  logic       unit_start;
  logic       wb_v;
  logic       wb_ready;
  logic       wb_fp;
  logic [4:0] wb_rd;
  logic       long_busy;
  logic       busy_iwb;
  logic       busy_fwb;
  logic [4:0] busy_rd;

  bp_be_long_ctl #(.lat_int_p(34), .lat_fp_p(20)) dut (
    .clk_i          (clk),
    .reset_i        (reset_n),
    .cmd_v_i        (cmd_v),
    .cmd_ready_o    (cmd_ready),
    .cmd_fp_i       (cmd_fp),
    .cmd_rd_addr_i  (cmd_rd),
    .flush_i        (flush),
    .unit_start_o   (unit_start),
    .wb_v_o         (wb_v),
    .wb_ready_i     (wb_ready),
    .wb_fp_o        (wb_fp),
    .wb_rd_addr_o   (wb_rd),
    .long_busy_o    (long_busy),
    .busy_iwb_v_o   (busy_iwb),
    .busy_fwb_v_o   (busy_fwb),
    .busy_rd_addr_o (busy_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         fp;
    logic [4:0] rd;
    int         stall;
    int         flush_k;
    bit         hold;
    int         exp_lat;
  } vec_t;

  typedef struct {
    bit         fp;
    logic [4:0] rd;
    int         due;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, int'(cmd_ready), 0);
    chk({tag, "_start"}, int'(unit_start), 0);
    chk({tag, "_wbv"}, int'(wb_v), 0);
    chk({tag, "_wbfp"}, int'(wb_fp), 0);
    chk({tag, "_wbrd"}, int'(wb_rd), 0);
    chk({tag, "_busy"}, int'(long_busy), 0);
    chk({tag, "_iwb"}, int'(busy_iwb), 0);
    chk({tag, "_fwb"}, int'(busy_fwb), 0);
    chk({tag, "_busyrd"}, int'(busy_rd), 0);
  endtask

  task automatic run_op(input vec_t v);
    int   k;
    bit   done;
    bit   seen;
    bit   exp_wbv;
    exp_t e;
    reset_n  = 1'b1;
    cmd_v    = 1'b1;
    cmd_fp   = v.fp;
    cmd_rd   = v.rd;
    flush    = 1'b0;
    wb_ready = 1'b0;
    #2;
    chk("acc_ready", int'(cmd_ready), 1);
    chk("acc_busy", int'(long_busy), 0);
    chk("acc_wbv", int'(wb_v), 0);
    sb.push_back('{fp: v.fp, rd: v.rd, due: cyc + v.exp_lat});
    tick();
    if (!v.hold) cmd_v = 1'b0;
    cmd_fp = ~v.fp;
    cmd_rd = ~v.rd;
    k = 1;
    done = 1'b0;
    seen = 1'b0;
    while (!done && k < 400) begin
      flush    = (v.flush_k == k);
      wb_ready = (k >= v.exp_lat + v.stall);
      #2;
      exp_wbv = !flush && (k >= v.exp_lat);
      chk("start", int'(unit_start), (k == 1) ? 1 : 0);
      chk("busy", int'(long_busy), 1);
      chk("iwb", int'(busy_iwb), v.fp ? 0 : 1);
      chk("fwb", int'(busy_fwb), v.fp ? 1 : 0);
      chk("busy_rd", int'(busy_rd), int'(v.rd));
      chk("ready_busy", int'(cmd_ready), 0);
      chk("wbv", int'(wb_v), exp_wbv ? 1 : 0);
      if (wb_v && !seen) begin
        seen = 1'b1;
        if (sb.size() > 0) chk("wb_due", cyc, sb[0].due);
      end
      if (wb_v) begin
        chk("wb_fp", int'(wb_fp), v.fp ? 1 : 0);
        chk("wb_rd", int'(wb_rd), int'(v.rd));
      end
      if (wb_v && wb_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_fp", int'(wb_fp), int'(e.fp));
          chk("sb_rd", int'(wb_rd), int'(e.rd));
        end
        done = 1'b1;
      end
      if (flush) begin
        if (sb.size() > 0) e = sb.pop_front();
        done = 1'b1;
      end
      tick();
      k++;
    end
    if (!done) chk("op_timeout", 0, 1);
    flush    = 1'b0;
    wb_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    //           fp    rd     stall flush_k hold  lat
    tbl[0] = '{1'b0, 5'd7,  0,  0,  1'b0, 34};
    tbl[1] = '{1'b1, 5'd3,  5,  0,  1'b0, 20};
    tbl[2] = '{1'b0, 5'd9,  0,  5,  1'b0, 34};
    tbl[3] = '{1'b0, 5'd12, 0,  34, 1'b0, 34};
    tbl[4] = '{1'b1, 5'd31, 2,  0,  1'b1, 20};
    tbl[5] = '{1'b0, 5'd0,  0,  0,  1'b1, 34};
    tbl[6] = '{1'b1, 5'd17, 10, 23, 1'b0, 20};
    tbl[7] = '{1'b1, 5'd1,  0,  0,  1'b0, 20};

    reset_n  = 1'b0;
    cmd_v    = 1'b1;
    cmd_fp   = 1'b1;
    cmd_rd   = 5'd21;
    flush    = 1'b0;
    wb_ready = 1'b1;
    #1;
    #2;
    chk_all_zero("rst");
    tick();
    tick();
    #2;
    chk_all_zero("rst2");
    reset_n = 1'b1;
    cmd_v   = 1'b0;
    #2;
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_busy", int'(long_busy), 0);
    chk("post_rst_busyrd", int'(busy_rd), 0);
    tick();

    // Flush while idle blocks the command.
    cmd_v = 1'b1;
    flush = 1'b1;
    #2;
    chk("idle_flush_ready", int'(cmd_ready), 0);
    tick();
    cmd_v = 1'b0;
    flush = 1'b0;
    #2;
    chk("idle_flush_busy", int'(long_busy), 0);
    chk("idle_flush_start", int'(unit_start), 0);
    tick();

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    // Reset pulse in the middle of an fp op.
    #2;
    chk("pre_rr_ready", int'(cmd_ready), 1);
    cmd_v  = 1'b1;
    cmd_fp = 1'b1;
    cmd_rd = 5'd5;
    tick();
    cmd_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_busy", int'(long_busy), 1);
      chk("rr_busyrd", int'(busy_rd), 5);
      tick();
    end
    reset_n = 1'b0;
    #2;
    chk_all_zero("midrst");
    tick();
    reset_n  = 1'b1;
    wb_ready = 1'b1;
    #2;
    chk("rr_ready", int'(cmd_ready), 1);
    chk("rr_busy_after", int'(long_busy), 0);
    for (int i = 0; i < 30; i++) begin
      #2;
      chk("rr_no_wb", int'(wb_v), 0);
      chk("rr_idle", int'(long_busy), 0);
      tick();
    end
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_be_long_ctl.md
BP_BE_LONG_CTL -- requirements
Module: bp_be_long_ctl

Interface
REQ-001 The block SHALL be a sequencer for the iterative long-latency unit (int div/rem, fp div/sqrt); it SHALL drive the long_busy input of the dispatch hazard detector and track the in-flight destination register.
REQ-002 Parameter: lat_int_p, 34, cycles from int command accept to result valid (legal range 2..255).
REQ-003 Parameter: lat_fp_p, 20, cycles from fp command accept to result valid (legal range 2..255).
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 cmd_v_i  input  1  long-op command valid from dispatch.
REQ-007 cmd_ready_o  output  1  block can accept a command this cycle.
REQ-008 cmd_fp_i  input  1  1 = fp op (result to FRF), 0 = int op (result to IRF).
REQ-009 cmd_rd_addr_i  input  5  destination register address.
REQ-010 flush_i  input  1  kill any in-flight op (exception/mispredict).
REQ-011 unit_start_o  output  1  one-cycle start pulse to the datapath unit.
REQ-012 wb_v_o  output  1  result ready for writeback.
REQ-013 wb_ready_i  input  1  writeback port accepts result.
REQ-014 wb_fp_o  output  1  writeback targets FRF.
REQ-015 wb_rd_addr_o  output  5  writeback destination.
REQ-016 long_busy_o  output  1  op in flight; blocks dispatch.
REQ-017 busy_iwb_v_o / busy_fwb_v_o  output  1 each  pending int / fp writeback to busy_rd_addr_o.
REQ-018 busy_rd_addr_o  output  5  destination of in-flight op.

Function
REQ-019 States SHALL be IDLE, RUN, WAIT_WB; internal registers: fp_r, rd_r (5b), cnt_r (8b).
REQ-020 cmd_ready_o SHALL equal (state==IDLE) & ~flush_i & reset_i.
REQ-021 Accept cycle T = cmd_v_i & cmd_ready_o; at T the block SHALL capture fp_r, rd_r, load cnt_r = lat-1 (lat = fp ? lat_fp_p : lat_int_p), and enter RUN at T+1.
REQ-022 unit_start_o SHALL be a registered pulse, high only in cycle T+1.
REQ-023 In RUN, cnt_r SHALL decrement by 1 per cycle; when cnt_r==1, next state SHALL be WAIT_WB, so wb_v_o first rises at cycle T+lat exactly.
REQ-024 wb_v_o SHALL equal (state==WAIT_WB) & ~flush_i; wb_fp_o = fp_r, wb_rd_addr_o = rd_r, stable while wb_v_o is held.
REQ-025 WAIT_WB SHALL hold indefinitely while wb_ready_i=0; on wb_v_o & wb_ready_i, next state SHALL be IDLE (earliest new accept T+lat+1; no same-cycle accept/retire).
REQ-026 flush_i=1 in RUN or WAIT_WB SHALL force IDLE next cycle with no wb_v_o, regardless of wb_ready_i; flush wins over a simultaneous writeback handshake.
REQ-027 flush_i=1 in IDLE SHALL block acceptance (cmd_ready_o=0) that cycle.
REQ-028 cmd_v_i while not ready SHALL be ignored, with no state change.
REQ-029 long_busy_o SHALL equal (state!=IDLE); busy_iwb_v_o = long_busy_o & ~fp_r; busy_fwb_v_o = long_busy_o & fp_r; busy_rd_addr_o = rd_r.
REQ-030 Counter arithmetic SHALL be unsigned 8-bit with no wrap; cnt_r SHALL never decrement below 1 in RUN.

Reset
REQ-031 On reset_i=0 at a clock edge: state=IDLE, cnt_r=0, fp_r=0, rd_r=0.
REQ-032 While reset_i=0, all outputs SHALL be 0 (including cmd_ready_o).
REQ-033 Reset in RUN or WAIT_WB SHALL abort the op with no wb_v_o; cmd_ready_o=1 in the first cycle after release.

Verification
REQ-034 Int cmd, rd=7, accepted at cycle 10, wb_ready_i=1 -> unit_start_o at 11; long_busy_o and busy_iwb_v_o high 11..44; wb_v_o only at 44 with rd 7; cmd_ready_o back at 45.
REQ-035 Fp cmd, rd=3, accepted at 0, wb_ready_i=0 until cycle 25 -> wb_v_o high 20..25, wb_fp_o=1, busy_fwb_v_o high 1..25, IDLE at 26.
REQ-036 Flush at cycle 15 of int op accepted at 10 -> IDLE at 16, no wb_v_o ever, next cmd accepted at 16.
REQ-037 Flush same cycle as wb_v_o & wb_ready_i -> wb_v_o=0 that cycle, no writeback, IDLE next.
REQ-038 reset_i=0 for 1 cycle mid-RUN -> all outputs 0 during reset, cmd_ready_o=1 after, no stale wb_v_o.
REQ-039 cmd_v_i held continuously from accept to retire -> exactly one accept per op; the second accept occurs the cycle after the wb handshake.
